knockout_bracket: RTL

//  Sequential single-elimination tournament engine for NUM_TEAMS seeded team IDs.

---
 rtl/knockout_pkg.sv | 16 +
 rtl/knockout_match_sel.sv | 14 +
 rtl/knockout_bracket.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/knockout_pkg.sv
// rtl/knockout_pkg.sv - shared types and helpers for the knockout bracket engine
package knockout_pkg;

  // Tournament engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of matches played in a given round of a num_teams bracket
  function automatic int matches_in_round(input int round, input int num_teams);
    return num_teams >> (round + 1);
  endfunction

endpackage

// File: rtl/knockout_match_sel.sv
// rtl/knockout_match_sel.sv - 2:1 winner select for a single match
module knockout_match_sel #(
  parameter int ID_W = 3
) (
  input  logic [ID_W-1:0] i_team_a,
  input  logic [ID_W-1:0] i_team_b,
  input  logic            i_result_sel,
  output logic [ID_W-1:0] o_winner
);

  // result_sel=1 means the odd-slot team advanced
  assign o_winner = i_result_sel ? i_team_b : i_team_a;

endmodule

// File: rtl/knockout_bracket.sv
// rtl/knockout_bracket.sv - sequential single-elimination tournament engine
module knockout_bracket
  import knockout_pkg::*;
#(
  parameter int NUM_TEAMS = 8,
  parameter int ID_W      = $clog2(NUM_TEAMS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_TEAMS*ID_W-1:0] seeds,
  output logic                      match_valid,
  output logic [ID_W-1:0]           team_a,
  output logic [ID_W-1:0]           team_b,
  output logic [ID_W-1:0]           round_o,
  output logic [ID_W-1:0]           match_o,
  input  logic                      result_valid,
  input  logic                      result_sel,
  output logic                      busy,
  output logic                      champion_valid,
  output logic [ID_W-1:0]           champion
);

  localparam int ROUNDS = $clog2(NUM_TEAMS);

  state_t          r_state;
  logic [ID_W-1:0] r_slot [NUM_TEAMS];
  logic [ID_W-1:0] r_round;
  logic [ID_W-1:0] r_match;
  logic [ID_W-1:0] r_champion;
  logic            r_match_valid;
  logic            r_busy;
  logic            r_champ_valid;

  logic [ID_W-1:0] w_idx_a;
  logic [ID_W-1:0] w_idx_b;
  logic [ID_W-1:0] w_team_a;
  logic [ID_W-1:0] w_team_b;
  logic [ID_W-1:0] w_winner;
  logic            w_accept;
  logic            w_start_ok;
  logic            w_last_match;
  logic            w_last_round;

  // Current pairing lives in the even/odd slot pair indexed by the match counter
  assign w_idx_a  = ID_W'(2 * r_match);
  assign w_idx_b  = ID_W'(2 * r_match + 1);
  assign w_team_a = r_slot[w_idx_a];
  assign w_team_b = r_slot[w_idx_b];

  assign w_accept     = r_match_valid & result_valid;
  assign w_start_ok   = start & ~abort & (r_state != ST_PLAY);
  assign w_last_match = (r_match == ID_W'(matches_in_round(int'(r_round), NUM_TEAMS) - 1));
  assign w_last_round = (r_round == ID_W'(ROUNDS - 1));

  knockout_match_sel #(
    .ID_W (ID_W)
  ) u_match_sel (
    .i_team_a     (w_team_a),
    .i_team_b     (w_team_b),
    .i_result_sel (result_sel),
    .o_winner     (w_winner)
  );

  // Slot array: seed load on start, in-place compaction of winners on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TEAMS; i++) r_slot[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < NUM_TEAMS; i++) r_slot[i] <= '0;
    end else if (w_start_ok) begin
      for (int i = 0; i < NUM_TEAMS; i++) r_slot[i] <= seeds[i*ID_W +: ID_W];
    end else if (w_accept) begin
      // match <= 2*match, so this write never clobbers a pairing still to be played
      r_slot[r_match] <= w_winner;
    end
  end

  // Tournament FSM with registered status outputs and round/match counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_round       <= '0;
      r_match       <= '0;
      r_champion    <= '0;
      r_match_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_champ_valid <= 1'b0;
    end else if (abort) begin
      r_state       <= ST_IDLE;
      r_round       <= '0;
      r_match       <= '0;
      r_champion    <= '0;
      r_match_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_champ_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_PLAY;
            r_round       <= '0;
            r_match       <= '0;
            r_champion    <= '0;
            r_match_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_champ_valid <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (w_accept) begin
            if (!w_last_match) begin
              r_match <= r_match + 1'b1;
            end else if (!w_last_round) begin
              r_round <= r_round + 1'b1;
              r_match <= '0;
            end else begin
              r_champion    <= w_winner;
              r_champ_valid <= 1'b1;
              r_match_valid <= 1'b0;
              r_busy        <= 1'b0;
              r_state       <= ST_DONE;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_match_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Pairing is only meaningful while a match is presented; keep it quiet otherwise
  assign team_a         = r_match_valid ? w_team_a : '0;
  assign team_b         = r_match_valid ? w_team_b : '0;
  assign match_valid    = r_match_valid;
  assign round_o        = r_round;
  assign match_o        = r_match;
  assign busy           = r_busy;
  assign champion_valid = r_champ_valid;
  assign champion       = r_champion;

endmodule
